mux_bank_pipe: RTL and testbench
================================

MUX_BANK_PIPE -- requirements
Module: mux_bank_pipe

Interface
REQ-001 SHALL have parameter CH, default 7, meaning number of independent mux channels (>=1).
REQ-002 SHALL have parameter W, default 8, meaning data width per channel (>=1).
REQ-003 SHALL have parameter NSRC, default 2, meaning sources per channel (>=2); SW = max(1, clog2(NSRC)).
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  CH*NSRC*W  channel c, source s at bits [(c*NSRC+s)*W +: W].
REQ-007 SHALL have port in_sel  input  CH*SW  channel c select at bits [c*SW +: SW].
REQ-008 SHALL have port in_valid  input  1  upstream offers a sample set.
REQ-009 SHALL have port in_ready  output  1  block accepts; in_valid&&in_ready = push.
REQ-010 SHALL have port out_data  output  CH*W  selected data, channel c at [c*W +: W].
REQ-011 SHALL have port out_sel_err  output  CH  per-channel flag: stored select was >= NSRC.
REQ-012 SHALL have port out_valid  output  1  out_data/out_sel_err hold a valid entry.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; out_valid&&out_ready = pop.
REQ-014 SHALL have port xfer_cnt  output  16  saturating count of pops since reset.

Function
REQ-015 SHALL compute, per channel, selected = in_data source in_sel when in_sel < NSRC, else zero with error bit 1.
REQ-016 SHALL store selection results (data + error bits) in a 2-entry FIFO skid buffer; no combinational path in_data->out_data.
REQ-017 SHALL implement states EMPTY, ONE, FULL; in_ready = (state != FULL); out_valid = (state != EMPTY); both driven from registers only.
REQ-018 SHALL transition EMPTY: push->ONE; ONE: push only->FULL, pop only->EMPTY, push+pop->ONE; FULL: pop->ONE, else hold.
REQ-019 SHALL have latency 1: sample pushed at edge N is on out_data in the cycle after edge N when buffer was EMPTY.
REQ-020 SHALL deliver entries in push order; out_data shows the oldest entry and SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL ignore in_valid while in FULL (no push, no data change).
REQ-022 SHALL ignore out_ready while EMPTY (no pop, counter unchanged).
REQ-023 SHALL sustain one push and one pop per cycle in state ONE (full throughput).
REQ-024 SHALL increment xfer_cnt by 1 per pop, saturating at 16'hFFFF (no wrap).
REQ-025 SHALL drive out_data and out_sel_err to zero whenever state is EMPTY.

Reset
REQ-026 SHALL on Reset=1 at an edge set state EMPTY, in_ready=1, out_valid=0, out_data=0, out_sel_err=0, xfer_cnt=0.
REQ-027 SHALL discard buffered entries on reset mid-operation; a push or pop coinciding with Reset SHALL have no effect.
REQ-028 SHALL ignore in_valid and out_ready while Reset is high.

Configuration
REQ-029 SHALL, when macro MUX_BANK_PARITY_EN is defined, add output out_par (CH bits): even-parity bit of each channel's stored W-bit data, stored with the entry, zero when EMPTY and on reset.
REQ-030 SHALL, without MUX_BANK_PARITY_EN, omit out_par and all parity storage; all other behaviour identical.

Verification
REQ-031 SHALL cover: CH=7,W=8,NSRC=2, ch0 sources {8'h11,8'h22}, sel=1, push into EMPTY with out_ready=1 -> next cycle out_valid=1, ch0 out_data=8'h22, xfer_cnt 0->1 at following edge.
REQ-032 SHALL cover: NSRC=3, SW=2, ch2 sel=2'd3 -> ch2 out_data=0, out_sel_err[2]=1, other channels unaffected.
REQ-033 SHALL cover: out_ready=0, push A, B, then C -> in_ready=0 after B, C not accepted; release out_ready -> pops A then B in order, then EMPTY.
REQ-034 SHALL cover: continuous in_valid=out_ready=1 for 100 cycles -> 100 pushes accepted, xfer_cnt=99 or 100 per latency, state stays ONE, no bubbles.
REQ-035 SHALL cover: Reset asserted in FULL with push+pop offered -> next cycle EMPTY, all outputs zero, xfer_cnt=0; with MUX_BANK_PARITY_EN, data 8'h07 -> out_par bit=1.

Source files
------------

// File: rtl/mux_bank_pipe.sv
// mux_bank_pipe: per-channel source select feeding a 2-entry skid FIFO with a saturating pop counter.
// Define MUX_BANK_PARITY_EN to add a stored per-channel even-parity output out_par.
module mux_bank_pipe #(
    parameter int CH = 7,
    parameter int W = 8,
    parameter int NSRC = 2,
    localparam int SW = (NSRC > 2) ? $clog2(NSRC) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [CH*NSRC*W-1:0]   in_data,
    input  logic [CH*SW-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [CH*W-1:0]        out_data,
    output logic [CH-1:0]          out_sel_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [15:0]            xfer_cnt
`ifdef MUX_BANK_PARITY_EN
    ,
    output logic [CH-1:0]          out_par
`endif
);
`ifdef MUX_BANK_PARITY_EN
    localparam int EW = CH*W + 2*CH;
`else
    localparam int EW = CH*W + CH;
`endif
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t         state_q;
    logic [EW-1:0]  head_q, skid_q, ent_d;
    logic [CH*W-1:0] data_d;
    logic [CH-1:0]  err_d;
    logic           in_ready_q, out_valid_q;
    logic [15:0]    cnt_q;
    logic           push, pop;

    // Out-of-range selects yield zero data and raise the channel's error bit.
    always_comb begin
        data_d = '0;
        err_d = '0;
        for (int c = 0; c < CH; c++) begin
            err_d[c] = int'(in_sel[c*SW +: SW]) >= NSRC;
            data_d[c*W +: W] = err_d[c] ? '0 : in_data[(c*NSRC + int'(in_sel[c*SW +: SW]))*W +: W];
        end
    end

`ifdef MUX_BANK_PARITY_EN
    logic [CH-1:0] par_d;
    always_comb begin
        par_d = '0;
        for (int c = 0; c < CH; c++) par_d[c] = ^data_d[c*W +: W];
    end
    assign ent_d = {par_d, err_d, data_d};
    assign out_par = head_q[EW-1 -: CH];
`else
    assign ent_d = {err_d, data_d};
`endif

    assign push = in_valid && in_ready_q;
    assign pop = out_valid_q && out_ready;
    assign in_ready = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data = head_q[CH*W-1:0];
    assign out_sel_err = head_q[CH*W +: CH];
    assign xfer_cnt = cnt_q;

    // Head always holds the oldest entry; vacated slots are cleared so EMPTY reads as zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= EMPTY;
            head_q <= '0;
            skid_q <= '0;
            in_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            cnt_q <= (pop && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
            case (state_q)
                EMPTY: if (push) begin
                    head_q <= ent_d;
                    state_q <= ONE;
                    out_valid_q <= 1'b1;
                end
                ONE: if (push && !pop) begin
                    skid_q <= ent_d;
                    state_q <= FULL;
                    in_ready_q <= 1'b0;
                end else if (pop) begin
                    head_q <= push ? ent_d : '0;
                    state_q <= push ? ONE : EMPTY;
                    out_valid_q <= push;
                end
                FULL: if (pop) begin
                    head_q <= skid_q;
                    skid_q <= '0;
                    state_q <= ONE;
                    in_ready_q <= 1'b1;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_bank_pipe.sv
// tb_mux_bank_pipe: two instances (NSRC=3 and default NSRC=2) driven in lockstep and checked
// every cycle against a queue-based reference model.
module tb_mux_bank_pipe;
    logic Clk = 1'b0;
    logic Reset, in_valid, out_ready;
    always #5 Clk = ~Clk;

    logic [167:0] da;
    logic [13:0]  sa;
    logic [111:0] db;
    logic [6:0]   sb;
    logic         ra, rb, va, vb;
    logic [55:0]  oda, odb;
    logic [6:0]   ea, eb;
    logic [15:0]  ca, cb;
`ifdef MUX_BANK_PARITY_EN
    logic [6:0]   pa, pb;
`endif

    mux_bank_pipe #(.CH(7), .W(8), .NSRC(3)) dut_a (
        .Clk(Clk), .Reset(Reset), .in_data(da), .in_sel(sa), .in_valid(in_valid),
        .in_ready(ra), .out_data(oda), .out_sel_err(ea), .out_valid(va),
        .out_ready(out_ready), .xfer_cnt(ca)
`ifdef MUX_BANK_PARITY_EN
        , .out_par(pa)
`endif
    );

    mux_bank_pipe dut_b (
        .Clk(Clk), .Reset(Reset), .in_data(db), .in_sel(sb), .in_valid(in_valid),
        .in_ready(rb), .out_data(odb), .out_sel_err(eb), .out_valid(vb),
        .out_ready(out_ready), .xfer_cnt(cb)
`ifdef MUX_BANK_PARITY_EN
        , .out_par(pb)
`endif
    );

    typedef struct {
        logic [55:0] d;
        logic [6:0]  e;
    } ent_t;
    ent_t qa[$], qb[$];
    int cnt_m = 0;
    int pushes = 0;
    int total = 0;
    int bad = 0;
    int c0;

    function automatic ent_t ref_sel(logic [167:0] data, logic [13:0] sel, int nsrc, int sw);
        ent_t r;
        r.d = '0;
        r.e = '0;
        for (int c = 0; c < 7; c++) begin
            int s;
            s = int'((sel >> (c*sw)) & ((14'd1 << sw) - 14'd1));
            if (s < nsrc) r.d[c*8 +: 8] = 8'(data >> ((c*nsrc + s)*8));
            else r.e[c] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [6:0] par_of(logic [55:0] d);
        logic [6:0] p;
        for (int c = 0; c < 7; c++) p[c] = ^d[c*8 +: 8];
        return p;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rnd();
        for (int i = 0; i < 21; i++) da[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < 14; i++) db[i*8 +: 8] = 8'($urandom);
        for (int i = 0; i < 7; i++) sa[i*2 +: 2] = 2'($urandom_range(0, 3));
        sb = 7'($urandom);
    endtask

    task automatic step();
        @(posedge Clk);
        if (Reset) begin
            qa.delete();
            qb.delete();
            cnt_m = 0;
        end else begin
            bit pu, po;
            pu = in_valid && qa.size() < 2;
            po = out_ready && qa.size() > 0;
            if (po) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
                if (cnt_m < 65535) cnt_m++;
            end
            if (pu) begin
                qa.push_back(ref_sel(da, sa, 3, 2));
                qb.push_back(ref_sel({56'b0, db}, {7'b0, sb}, 2, 1));
                pushes++;
            end
        end
        #1;
        chk("a_in_ready", ra, qa.size() < 2);
        chk("a_out_valid", va, qa.size() > 0);
        chk("a_out_data", oda, qa.size() > 0 ? qa[0].d : 56'b0);
        chk("a_sel_err", ea, qa.size() > 0 ? qa[0].e : 7'b0);
        chk("a_xfer_cnt", ca, cnt_m);
        chk("b_in_ready", rb, qb.size() < 2);
        chk("b_out_valid", vb, qb.size() > 0);
        chk("b_out_data", odb, qb.size() > 0 ? qb[0].d : 56'b0);
        chk("b_sel_err", eb, qb.size() > 0 ? qb[0].e : 7'b0);
        chk("b_xfer_cnt", cb, cnt_m);
`ifdef MUX_BANK_PARITY_EN
        chk("a_par", pa, qa.size() > 0 ? par_of(qa[0].d) : 7'b0);
        chk("b_par", pb, qb.size() > 0 ? par_of(qb[0].d) : 7'b0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        rnd();
        step();
        step();
        Reset = 1'b0;
        in_valid = 1'b0;
        step();
        // push into EMPTY, visible next cycle, counted at the following edge
        rnd();
        db[15:0] = 16'h2211;
        sb[0] = 1'b1;
        in_valid = 1'b1;
        step();
        chk("r31_b_ch0", odb[7:0], 8'h22);
        chk("r31_valid", vb, 1'b1);
        chk("r31_cnt0", cb, 16'd0);
        in_valid = 1'b0;
        step();
        chk("r31_cnt1", cb, 16'd1);
        // out-of-range select on channel 2
        rnd();
        sa[5:4] = 2'd3;
        in_valid = 1'b1;
        step();
        chk("r32_err2", ea[2], 1'b1);
        chk("r32_data2", oda[23:16], 8'h00);
        in_valid = 1'b0;
        step();
        // fill to FULL, third push ignored, drain in order
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd();
        step();
        rnd();
        step();
        chk("r33_full", ra, 1'b0);
        rnd();
        step();
        chk("r33_still_full", ra, 1'b0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("r33_empty", va, 1'b0);
        // sustained throughput
        pushes = 0;
        c0 = cnt_m;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rnd();
            step();
        end
        chk("r34_pushes", pushes, 100);
        chk("r34_pops", 32'(ca) - 32'(c0), 99);
        in_valid = 1'b0;
        step();
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rnd();
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = 1'($urandom);
            step();
        end
        // reset while FULL with push and pop offered
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd();
        da[7:0] = 8'h07;
        sa[1:0] = 2'd0;
        step();
`ifdef MUX_BANK_PARITY_EN
        chk("r35_par07", pa[0], 1'b1);
`endif
        rnd();
        step();
        chk("r35_full", ra, 1'b0);
        Reset = 1'b1;
        out_ready = 1'b1;
        rnd();
        step();
        chk("r35_valid", va, 1'b0);
        chk("r35_data", oda, 56'b0);
        chk("r35_cnt", ca, 16'd0);
        chk("r35_ready", ra, 1'b1);
        Reset = 1'b0;
        in_valid = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
